// File: rtl/hazard_unit_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
// Carries the stage register fields the controller inspects and the controls it returns.
interface hazard_unit_if #(
  parameter int unsigned RegW = 5,
  parameter int unsigned CntW = 16
);
  logic [RegW-1:0] ra1_d;
  logic [RegW-1:0] ra2_d;
  logic [RegW-1:0] ra1_e;
  logic [RegW-1:0] ra2_e;
  logic [RegW-1:0] wa3_e;
  logic            reg_write_e;
  logic            mem_to_reg_e;
  logic            branch_taken_e;
  logic            mem_ready_m;
  logic            cnt_clr;

  logic [1:0]      forward_ae;
  logic [1:0]      forward_be;
  logic            stall_f;
  logic            stall_d;
  logic            stall_e;
  logic            flush_d;
  logic            flush_e;
  logic [CntW-1:0] stall_cnt;
  logic [CntW-1:0] flush_cnt;

  modport master (
    output ra1_d, ra2_d, ra1_e, ra2_e, wa3_e, reg_write_e, mem_to_reg_e,
           branch_taken_e, mem_ready_m, cnt_clr,
    input  forward_ae, forward_be, stall_f, stall_d, stall_e, flush_d, flush_e,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  ra1_d, ra2_d, ra1_e, ra2_e, wa3_e, reg_write_e, mem_to_reg_e,
           branch_taken_e, mem_ready_m, cnt_clr,
    output forward_ae, forward_be, stall_f, stall_d, stall_e, flush_d, flush_e,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: forwarding selects, stall/flush controls, private M/W shadows
// of the destination register, and saturating stall/flush event counters.
module hazard_unit #(
  parameter int unsigned RegW = 5,
  parameter int unsigned CntW = 16
) (
  input logic         clk_i,
  input logic         rst_ni,
  hazard_unit_if.slave hz
);

  localparam logic [CntW-1:0] CntMax = '1;
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [RegW-1:0] wa3_m_q, wa3_m_d;
  logic [RegW-1:0] wa3_w_q, wa3_w_d;
  logic            reg_write_m_q, reg_write_m_d;
  logic            reg_write_w_q, reg_write_w_d;
  logic [CntW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CntW-1:0] flush_cnt_q, flush_cnt_d;

  logic mem_wait;
  logic ld_stall;
  logic stall_d;
  logic flush_e;

  // Forwarding: the Memory-stage result is younger, so it wins over Writeback.
  always_comb begin
    hz.forward_ae = 2'b00;
    hz.forward_be = 2'b00;
    if (reg_write_m_q && (wa3_m_q == hz.ra1_e)) begin
      hz.forward_ae = 2'b10;
    end else if (reg_write_w_q && (wa3_w_q == hz.ra1_e)) begin
      hz.forward_ae = 2'b01;
    end
    if (reg_write_m_q && (wa3_m_q == hz.ra2_e)) begin
      hz.forward_be = 2'b10;
    end else if (reg_write_w_q && (wa3_w_q == hz.ra2_e)) begin
      hz.forward_be = 2'b01;
    end
  end

  // A memory wait freezes everything and defers flushes; a taken branch beats a load-use stall.
  always_comb begin
    mem_wait   = ~hz.mem_ready_m;
    ld_stall   = hz.mem_to_reg_e & hz.reg_write_e &
                 ((hz.wa3_e == hz.ra1_d) | (hz.wa3_e == hz.ra2_d));
    stall_d    = mem_wait | (ld_stall & ~hz.branch_taken_e);
    flush_e    = (ld_stall | hz.branch_taken_e) & ~mem_wait;
    hz.stall_e = mem_wait;
    hz.stall_f = stall_d;
    hz.stall_d = stall_d;
    hz.flush_d = hz.branch_taken_e & ~mem_wait;
    hz.flush_e = flush_e;
  end

  // RegWriteE is already masked by the CLR of the Decode->Execute register.
  always_comb begin
    wa3_m_d       = wa3_m_q;
    wa3_w_d       = wa3_w_q;
    reg_write_m_d = reg_write_m_q;
    reg_write_w_d = reg_write_w_q;
    if (hz.mem_ready_m) begin
      wa3_m_d       = hz.wa3_e;
      reg_write_m_d = hz.reg_write_e;
      wa3_w_d       = wa3_m_q;
      reg_write_w_d = reg_write_m_q;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz.cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_d && (stall_cnt_q != CntMax)) begin
        stall_cnt_d = stall_cnt_q + CntOne;
      end
      if (flush_e && (flush_cnt_q != CntMax)) begin
        flush_cnt_d = flush_cnt_q + CntOne;
      end
    end
  end

  // State follows the pipeline registers, which update on the falling edge.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wa3_m_q       <= '0;
      wa3_w_q       <= '0;
      reg_write_m_q <= 1'b0;
      reg_write_w_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      wa3_m_q       <= wa3_m_d;
      wa3_w_q       <= wa3_w_d;
      reg_write_m_q <= reg_write_m_d;
      reg_write_w_q <= reg_write_w_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule
